// File: rtl/refresh_scheduler.sv
// refresh_scheduler: per-rank refresh debt tracking with a single shared PREA/REF sequencer
module refresh_scheduler #(
  parameter int NUM_RNK_TOT = 2,
  parameter int RNK_SEL_WIDTH = 1,
  parameter int CMD_TYPE_WIDTH = 3,
  parameter logic [CMD_TYPE_WIDTH-1:0] CMD_PREA = 3'd5,
  parameter logic [CMD_TYPE_WIDTH-1:0] CMD_REF = 3'd6,
  parameter int TREFI = 16,
  parameter int TRP = 3,
  parameter int TRFC = 10,
  parameter int MAX_DEBT = 8,
  parameter int URGENT_DEBT = 4,
  parameter int CNT_WIDTH = 8,
  parameter real TCQ = 0.1
) (
  input  logic                      i_clk,
  input  logic                      i_rstn,
  input  logic                      i_enable,
  input  logic [NUM_RNK_TOT-1:0]    i_rank_quiet,
  input  logic                      i_ref_ready,
  output logic [NUM_RNK_TOT-1:0]    o_block_rank,
  output logic                      o_ref_valid,
  output logic [CMD_TYPE_WIDTH-1:0] o_ref_cmd,
  output logic [RNK_SEL_WIDTH-1:0]  o_ref_rank,
  output logic [NUM_RNK_TOT-1:0]    o_urgent,
  output logic                      o_overflow
);
  localparam int DW = $clog2(MAX_DEBT + 1);
  typedef enum logic [2:0] {IDLE, BLOCK, PREA, WAIT_RP, REF, WAIT_RFC} state_t;
  state_t state, state_nxt;
  logic [CNT_WIDTH-1:0] ivl [NUM_RNK_TOT];
  logic [DW-1:0] debt [NUM_RNK_TOT];
  logic [CNT_WIDTH-1:0] timer, timer_nxt;
  logic [RNK_SEL_WIDTH-1:0] target, target_nxt, pick;
  logic [NUM_RNK_TOT-1:0] tick, done, full;
  logic found;
  // per-rank tick/completion/saturation flags, urgency, and rank selection (urgent first, lowest index wins)
  always_comb begin
    tick = '0;
    done = '0;
    full = '0;
    o_urgent = '0;
    found = 1'b0;
    pick = '0;
    for (int r = 0; r < NUM_RNK_TOT; r++) begin
      tick[r] = i_enable && ivl[r] == '0;
      done[r] = state == WAIT_RFC && timer == '0 && target == RNK_SEL_WIDTH'(r);
      full[r] = debt[r] == DW'(MAX_DEBT);
      o_urgent[r] = debt[r] >= DW'(URGENT_DEBT);
    end
    for (int r = NUM_RNK_TOT - 1; r >= 0; r--)
      if (debt[r] != '0 && i_rank_quiet[r]) begin
        found = 1'b1;
        pick = RNK_SEL_WIDTH'(r);
      end
    for (int r = NUM_RNK_TOT - 1; r >= 0; r--)
      if (o_urgent[r]) begin
        found = 1'b1;
        pick = RNK_SEL_WIDTH'(r);
      end
  end
  // interval counters, saturating debt (tick and completion in one cycle cancel) and sticky overflow
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      for (int r = 0; r < NUM_RNK_TOT; r++) begin
        ivl[r] <= CNT_WIDTH'(TREFI - 1);
        debt[r] <= '0;
      end
      o_overflow <= 1'b0;
    end else begin
      for (int r = 0; r < NUM_RNK_TOT; r++) begin
        if (i_enable) ivl[r] <= tick[r] ? CNT_WIDTH'(TREFI - 1) : ivl[r] - CNT_WIDTH'(1);
        if (tick[r] && !done[r] && !full[r]) debt[r] <= debt[r] + DW'(1);
        else if (done[r] && !tick[r] && debt[r] != '0) debt[r] <= debt[r] - DW'(1);
      end
      if (|(tick & ~done & full)) o_overflow <= 1'b1;
    end
  end
  // sequencer state, service timer and latched target rank
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state <= IDLE;
      timer <= '0;
      target <= '0;
    end else begin
      state <= state_nxt;
      timer <= timer_nxt;
      target <= target_nxt;
    end
  end
  // next-state logic and refresh-path outputs; the target stays blocked for the whole service
  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    target_nxt = target;
    o_block_rank = '0;
    o_ref_valid = 1'b0;
    o_ref_cmd = '0;
    o_ref_rank = '0;
    if (state != IDLE) o_block_rank[target] = 1'b1;
    case (state)
      IDLE: if (i_enable && found) begin
        state_nxt = BLOCK;
        target_nxt = pick;
      end
      BLOCK: if (i_rank_quiet[target]) state_nxt = PREA;
      PREA: begin
        o_ref_valid = 1'b1;
        o_ref_cmd = CMD_PREA;
        if (i_ref_ready) begin
          timer_nxt = CNT_WIDTH'(TRP - 1);
          state_nxt = WAIT_RP;
        end
      end
      WAIT_RP: if (timer == '0) state_nxt = REF; else timer_nxt = timer - CNT_WIDTH'(1);
      REF: begin
        o_ref_valid = 1'b1;
        o_ref_cmd = CMD_REF;
        if (i_ref_ready) begin
          timer_nxt = CNT_WIDTH'(TRFC - 1);
          state_nxt = WAIT_RFC;
        end
      end
      WAIT_RFC: if (timer == '0) state_nxt = IDLE; else timer_nxt = timer - CNT_WIDTH'(1);
      default: state_nxt = IDLE;
    endcase
    if (o_ref_valid) o_ref_rank = target;
  end
endmodule

// File: tb/tb_refresh_scheduler.sv
// tb_refresh_scheduler: scenario tasks plus randomized traffic checked against a timestamp-based model
module tb_refresh_scheduler;
  localparam int TREFI = 16, TRP = 3, TRFC = 10, MAX_DEBT = 8, URGENT = 4;
  logic i_clk = 1'b0, i_rstn = 1'b0, i_enable = 1'b0, i_ref_ready = 1'b0;
  logic [1:0] i_rank_quiet = 2'b00;
  logic [1:0] o_block_rank, o_urgent;
  logic o_ref_valid, o_overflow;
  logic [2:0] o_ref_cmd;
  logic [0:0] o_ref_rank;
  int nchk = 0, nerr = 0;
  // model state: debts, enabled-edge count, and the current service described by edge timestamps
  int debt [2];
  int en_edges, now, tgt, prea_e, ref_e;
  bit ovf, busy, pre_ok;
  logic [1:0] exp_block, exp_urgent;
  logic exp_valid, exp_rank;
  logic [2:0] exp_cmd;
  wire [9:0] obs = {o_block_rank, o_ref_valid, o_ref_cmd, o_ref_rank, o_urgent, o_overflow};
  wire [9:0] want = {exp_block, exp_valid, exp_cmd, exp_rank, exp_urgent, ovf};
  refresh_scheduler dut (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_enable(i_enable), .i_rank_quiet(i_rank_quiet),
    .i_ref_ready(i_ref_ready), .o_block_rank(o_block_rank), .o_ref_valid(o_ref_valid),
    .o_ref_cmd(o_ref_cmd), .o_ref_rank(o_ref_rank), .o_urgent(o_urgent), .o_overflow(o_overflow)
  );
  always #5 i_clk = ~i_clk;
  task automatic model_eval();
    exp_block = 2'b00;
    exp_valid = 1'b0;
    exp_cmd = 3'd0;
    exp_rank = 1'b0;
    if (busy) begin
      exp_block[tgt] = 1'b1;
      if (pre_ok && prea_e < 0) begin
        exp_valid = 1'b1;
        exp_cmd = 3'd5;
      end else if (prea_e >= 0 && ref_e < 0 && now >= prea_e + TRP) begin
        exp_valid = 1'b1;
        exp_cmd = 3'd6;
      end
      if (exp_valid) exp_rank = tgt[0];
    end
    for (int r = 0; r < 2; r++) exp_urgent[r] = debt[r] >= URGENT;
  endtask
  task automatic model_reset();
    debt[0] = 0;
    debt[1] = 0;
    en_edges = 0;
    now = 0;
    ovf = 0;
    busy = 0;
    model_eval();
  endtask
  task automatic model_edge();
    bit tk, cmp, d;
    int sel;
    tk = i_enable && ((en_edges + 1) % TREFI == 0);
    if (i_enable) en_edges++;
    cmp = busy && ref_e >= 0 && now + 1 == ref_e + TRFC;
    sel = -1;
    if (!busy && i_enable) begin
      for (int r = 1; r >= 0; r--) if (debt[r] > 0 && i_rank_quiet[r]) sel = r;
      for (int r = 1; r >= 0; r--) if (debt[r] >= URGENT) sel = r;
    end
    for (int r = 0; r < 2; r++) begin
      d = cmp && r == tgt;
      if (tk && !d) begin
        if (debt[r] == MAX_DEBT) ovf = 1;
        else debt[r]++;
      end else if (d && !tk) debt[r]--;
    end
    if (busy) begin
      if (exp_valid && i_ref_ready) begin
        if (exp_cmd == 3'd5) prea_e = now + 1;
        else ref_e = now + 1;
      end
      if (!pre_ok && i_rank_quiet[tgt]) pre_ok = 1;
      if (cmp) busy = 0;
    end else if (sel >= 0) begin
      busy = 1;
      tgt = sel;
      pre_ok = 0;
      prea_e = -1;
      ref_e = -1;
    end
    now++;
    model_eval();
  endtask
  task automatic step();
    @(posedge i_clk);
    model_edge();
    @(negedge i_clk);
  endtask
  task automatic do_reset();
    i_rstn = 1'b0;
    i_enable = 1'b0;
    i_rank_quiet = 2'b00;
    i_ref_ready = 1'b0;
    repeat (2) @(negedge i_clk);
    i_rstn = 1'b1;
    model_reset();
  endtask
  task automatic test_reset();
    i_enable = 1'b1;
    i_rank_quiet = 2'b11;
    i_ref_ready = 1'b1;
    @(negedge i_clk);
    @(negedge i_clk);
    nchk++;
    if (obs !== 10'd0) begin
      nerr++;
      $display("FAIL reset_outputs got %b want %b", obs, 10'd0);
    end
    do_reset();
    nchk++;
    if (obs !== want) begin
      nerr++;
      $display("FAIL reset_release got %b want %b", obs, want);
    end
  endtask
  task automatic test_opportunistic();
    int first;
    bit saw1;
    do_reset();
    i_enable = 1'b1;
    i_rank_quiet = 2'b11;
    i_ref_ready = 1'b1;
    first = -1;
    saw1 = 0;
    for (int k = 1; k <= 120; k++) begin
      step();
      nchk++;
      if (obs !== want) begin
        nerr++;
        $display("FAIL opportunistic@%0d got %b want %b", k, obs, want);
      end
      if (first < 0 && o_block_rank != 2'b00) first = k;
      if (o_block_rank == 2'b10) saw1 = 1;
    end
    nchk++;
    if (first !== 17) begin
      nerr++;
      $display("FAIL first_block_edge got %0d want 17", first);
    end
    nchk++;
    if (saw1 !== 1'b1) begin
      nerr++;
      $display("FAIL rank1_serviced got %0d want 1", saw1);
    end
  endtask
  task automatic test_force();
    do_reset();
    i_enable = 1'b1;
    i_rank_quiet = 2'b00;
    i_ref_ready = 1'b1;
    for (int k = 1; k <= 70; k++) begin
      step();
      nchk++;
      if (obs !== want) begin
        nerr++;
        $display("FAIL force@%0d got %b want %b", k, obs, want);
      end
      if (k == 64) begin
        nchk++;
        if (o_urgent !== 2'b11) begin
          nerr++;
          $display("FAIL urgent_at_4 got %b want 11", o_urgent);
        end
      end
    end
    nchk++;
    if ({o_block_rank, o_ref_valid} !== 3'b010) begin
      nerr++;
      $display("FAIL block_withheld got %b want 010", {o_block_rank, o_ref_valid});
    end
    i_rank_quiet = 2'b01;
    step();
    nchk++;
    if ({o_ref_valid, o_ref_cmd, o_ref_rank} !== 5'b1_101_0) begin
      nerr++;
      $display("FAIL forced_prea got %b want 11010", {o_ref_valid, o_ref_cmd, o_ref_rank});
    end
    for (int k = 0; k < 30; k++) begin
      step();
      nchk++;
      if (obs !== want) begin
        nerr++;
        $display("FAIL force_tail@%0d got %b want %b", k, obs, want);
      end
    end
  endtask
  task automatic test_backpressure();
    int n;
    do_reset();
    i_enable = 1'b1;
    i_rank_quiet = 2'b11;
    i_ref_ready = 1'b0;
    n = 0;
    while (!o_ref_valid && n < 40) begin
      step();
      n++;
      nchk++;
      if (obs !== want) begin
        nerr++;
        $display("FAIL bp_wait@%0d got %b want %b", n, obs, want);
      end
    end
    nchk++;
    if (o_ref_valid !== 1'b1) begin
      nerr++;
      $display("FAIL bp_timeout got valid=%b want 1", o_ref_valid);
    end
    for (int k = 0; k < 4; k++) begin
      step();
      nchk++;
      if ({o_ref_valid, o_ref_cmd, o_ref_rank} !== 5'b1_101_0 || obs !== want) begin
        nerr++;
        $display("FAIL bp_hold@%0d got %b want %b", k, obs, want);
      end
    end
    i_ref_ready = 1'b1;
    step();
    nchk++;
    if (o_ref_valid !== 1'b0 || obs !== want) begin
      nerr++;
      $display("FAIL bp_accept got %b want %b", obs, want);
    end
  endtask
  task automatic test_saturation();
    do_reset();
    i_enable = 1'b1;
    i_rank_quiet = 2'b00;
    i_ref_ready = 1'b1;
    for (int k = 1; k <= 9 * TREFI + 20; k++) begin
      step();
      nchk++;
      if (obs !== want) begin
        nerr++;
        $display("FAIL saturation@%0d got %b want %b", k, obs, want);
      end
      if (k == 9 * TREFI - 1 || k == 9 * TREFI || k == 9 * TREFI + 20) begin
        nchk++;
        if (o_overflow !== (k >= 9 * TREFI)) begin
          nerr++;
          $display("FAIL overflow@%0d got %b want %b", k, o_overflow, k >= 9 * TREFI);
        end
      end
    end
  endtask
  task automatic test_mid_reset();
    int n, first;
    do_reset();
    i_enable = 1'b1;
    i_rank_quiet = 2'b11;
    i_ref_ready = 1'b1;
    n = 0;
    while (!(busy && ref_e >= 0) && n < 60) begin
      step();
      n++;
    end
    step();
    nchk++;
    if (o_block_rank !== 2'b01) begin
      nerr++;
      $display("FAIL mid_reset_setup got %b want 01", o_block_rank);
    end
    #2 i_rstn = 1'b0;
    #1;
    nchk++;
    if (obs !== 10'd0) begin
      nerr++;
      $display("FAIL async_reset got %b want %b", obs, 10'd0);
    end
    repeat (3) @(negedge i_clk);
    i_rstn = 1'b1;
    model_reset();
    first = -1;
    for (int k = 1; k <= 18; k++) begin
      step();
      nchk++;
      if (obs !== want) begin
        nerr++;
        $display("FAIL post_reset@%0d got %b want %b", k, obs, want);
      end
      if (first < 0 && o_block_rank != 2'b00) first = k;
    end
    nchk++;
    if (first !== 17) begin
      nerr++;
      $display("FAIL post_reset_tick got %0d want 17", first);
    end
  endtask
  task automatic test_back_to_back();
    do_reset();
    i_rank_quiet = 2'b01;
    i_ref_ready = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      i_enable = (k != 20);
      step();
      nchk++;
      if (obs !== want) begin
        nerr++;
        $display("FAIL b2b@%0d got %b want %b", k, obs, want);
      end
      if (k == 33 || k == 34) begin
        nchk++;
        if (o_block_rank !== (k == 33 ? 2'b00 : 2'b01)) begin
          nerr++;
          $display("FAIL reselect@%0d got %b want %b", k, o_block_rank, k == 33 ? 2'b00 : 2'b01);
        end
      end
    end
  endtask
  task automatic test_random();
    do_reset();
    for (int k = 0; k < 800; k++) begin
      i_enable = $urandom_range(0, 9) != 0;
      i_rank_quiet = 2'($urandom);
      i_ref_ready = $urandom_range(0, 3) != 0;
      step();
      nchk++;
      if (obs !== want) begin
        nerr++;
        $display("FAIL random@%0d got %b want %b", k, obs, want);
      end
    end
  endtask
  initial begin
    test_reset();
    test_opportunistic();
    test_force();
    test_backpressure();
    test_saturation();
    test_mid_reset();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
